// File: rtl/tck_step_gen.sv
// -----------------------------------------------------------------------------
// tck_step_gen
//
// Step controller that sits after the TCK clock divider. The divider's TCK-rate
// output (tck_tick) is treated as a sampled level, never as a clock. Each rising
// edge of that level becomes one TCK half-period inside the clk_in domain. The
// block drives a glitch-free TCK to the JTAG shift engine in one of four modes:
// stopped, free-running, single step or N-cycle burst.
//
// Optional feature macro: TCK_STEP_COUNT_EN
//   defined   : tck_count counts every tck_fall and wraps at 2^32.
//   undefined : tck_count is tied to zero and no counter flops exist.
//
// Ports
//   clk_in     in   1      system clock; all logic on its rising edge
//   reset      in   1      synchronous reset, active low
//   tck_tick   in   1      divider TCK-rate level, asynchronous to clk_in
//   mode       in   2      00 stop, 01 free-run, 10 single step, 11 burst
//   step_req   in   1      one-cycle start pulse for modes 10/11
//   burst_len  in   CNT_W  TCK cycles per burst, sampled at burst start
//   tck        out  1      generated TCK, idles low
//   tck_rise   out  1      strobe in the cycle tck goes 0->1
//   tck_fall   out  1      strobe in the cycle tck goes 1->0
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse when a step or burst completes
//   tck_count  out  32     completed TCK cycles (see macro above)
// -----------------------------------------------------------------------------
module tck_step_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tck_tick,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic [CNT_W-1:0] burst_len,
    output logic             tck,
    output logic             tck_rise,
    output logic             tck_fall,
    output logic             busy,
    output logic             done,
    output logic [31:0]      tck_count
);

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_BURST,
        ST_STOPPING
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_half_tick;
    logic             r_tck;
    logic             w_tck_nxt;
    logic             r_tck_rise;
    logic             r_tck_fall;
    logic             r_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;

    // Two-flop synchronizer plus a history flop for edge detection. The
    // detected edge is registered once more so the FSM sees a clean single
    // cycle event: tick sampled at edge k -> tck toggles at edge k+3.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_half_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds the shift chain.
            r_s1        <= tck_tick;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_half_tick <= r_s2 & ~r_s3;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_tck_nxt       = r_tck;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tck_nxt = 1'b0;
                if (mode == MODE_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (mode == MODE_STEP && step_req) begin
                    w_state_nxt     = ST_STEP;
                    w_remaining_nxt = CNT_W'(1);
                end else if (mode == MODE_BURST && step_req) begin
                    if (burst_len != '0) begin
                        w_state_nxt     = ST_BURST;
                        w_remaining_nxt = burst_len;
                    end else begin
                        // Empty burst: report completion without any TCK edge.
                        w_done_nxt = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (mode != MODE_RUN) begin
                    // Never cut a high phase short; finish it in STOPPING.
                    w_state_nxt = r_tck ? ST_STOPPING : ST_IDLE;
                end else if (r_half_tick) begin
                    w_tck_nxt = ~r_tck;
                end
            end

            ST_STEP, ST_BURST: begin
                if (mode == MODE_STOP) begin
                    w_state_nxt     = r_tck ? ST_STOPPING : ST_IDLE;
                    w_remaining_nxt = '0;
                end else if (r_half_tick) begin
                    w_tck_nxt = ~r_tck;
                    // A falling edge completes one TCK cycle.
                    if (r_tck && r_remaining != '0) begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end

            ST_STOPPING: begin
                if (r_half_tick) begin
                    w_tck_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_tck_nxt       = 1'b0;
                w_remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_tck       <= 1'b0;
            r_tck_rise  <= 1'b0;
            r_tck_fall  <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tck       <= w_tck_nxt;
            r_tck_rise  <= w_tck_nxt & ~r_tck;
            r_tck_fall  <= ~w_tck_nxt & r_tck;
            r_done      <= w_done_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

`ifdef TCK_STEP_COUNT_EN
    logic        w_fall;
    logic [31:0] r_tck_count;

    assign w_fall = r_tck & ~w_tck_nxt;

    // Updates on the same edge that raises tck_fall; wraps naturally.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_tck_count <= '0;
        end else if (w_fall) begin
            r_tck_count <= r_tck_count + 32'd1;
        end
    end

    assign tck_count = r_tck_count;
`else
    assign tck_count = '0;
`endif

    assign tck      = r_tck;
    assign tck_rise = r_tck_rise;
    assign tck_fall = r_tck_fall;
    assign done     = r_done;
    assign busy     = (r_state != ST_IDLE);

endmodule
